// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit for HI/LO: radix-2 shift-add multiply and
// restoring divide on magnitudes, a one-cycle sign fixup, fixed 34-cycle latency.
module mult_div_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        DivByZero
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [5:0]  cnt;
    logic [31:0] hi, lo, b_mag, a_raw;
    logic        is_div, neg_q, neg_r, dbz;

    logic        sgn_in;
    logic [31:0] a_mag_in, b_mag_in;
    logic [32:0] add_sum;
    logic [32:0] div_sh;
    logic        div_ok;
    logic [31:0] div_diff;
    logic [63:0] prod_neg;
    logic [31:0] hi_fix, lo_fix;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE:    if (Start) begin accept = 1'b1; state_nxt = CALC; end
            CALC:    if (cnt == 6'd31) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (Start) begin accept = 1'b1; state_nxt = CALC; end
                     else state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign Busy = (state == CALC) || (state == FIXUP);

    // Op[0]==0 selects the signed variants (MULT, DIV)
    assign sgn_in   = ~Op[0];
    assign a_mag_in = (sgn_in && A[31]) ? -A : A;
    assign b_mag_in = (sgn_in && B[31]) ? -B : B;

    // Multiplier sits in lo and shifts out as the product shifts in from hi
    assign add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : 33'd0);
    // Partial remainder in hi, dividend/quotient in lo; remainder < divisor keeps hi at 32 bits
    assign div_sh   = {hi, lo[31]};
    assign div_ok   = div_sh >= {1'b0, b_mag};
    assign div_diff = div_sh[31:0] - b_mag;

    assign prod_neg = -{hi, lo};

    always_comb begin
        hi_fix = hi;
        lo_fix = lo;
        if (dbz) begin
            hi_fix = a_raw;
            lo_fix = 32'hFFFF_FFFF;
        end else if (is_div) begin
            lo_fix = neg_q ? -lo : lo;
            hi_fix = neg_r ? -hi : hi;
        end else if (neg_q) begin
            {hi_fix, lo_fix} = prod_neg;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            b_mag  <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= a_mag_in;
            b_mag  <= b_mag_in;
            a_raw  <= A;
            is_div <= Op[1];
            neg_q  <= sgn_in & (A[31] ^ B[31]);
            neg_r  <= sgn_in & Op[1] & A[31];
            dbz    <= Op[1] & (B == 32'd0);
        end else if (state == CALC) begin
            cnt <= cnt + 6'd1;
            if (is_div) begin
                hi <= div_ok ? div_diff : div_sh[31:0];
                lo <= {lo[30:0], div_ok};
            end else begin
                hi <= add_sum[32:1];
                lo <= {add_sum[0], lo[31:1]};
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            HiOut     <= '0;
            LoOut     <= '0;
        end else begin
            Done      <= (state == FIXUP);
            DivByZero <= (state == FIXUP) & dbz;
            if (state == FIXUP) begin
                HiOut <= hi_fix;
                LoOut <= lo_fix;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/flag and accept cycle are queued
// at issue time and compared, with latency, whenever Done pulses.
module tb_mult_div_unit;
    logic        Clk, Rst, Start, Busy, Done, DivByZero;
    logic [1:0]  Op;
    logic [31:0] A, B, HiOut, LoOut;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t scb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    mult_div_unit dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .HiOut(HiOut), .LoOut(LoOut), .DivByZero(DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        e.cyc = 0;
        e.hi  = '0;
        e.lo  = '0;
        case (op)
            2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                end else if (op == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Caller is away from the rising edge; the next rising edge accepts
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk);
        #1;
        e = model(op, a, b);
        e.cyc = cyc;
        scb.push_back(e);
        Start = 1'b0;
        Op = 2'($urandom_range(0, 3));
        A = $urandom;
        B = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Done && n < 100);
        if (!Done) chk("done_timeout", {63'd0, Done}, 64'd1);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!Rst && Done) begin
            if (scb.size() == 0) chk("spurious_done", {63'd0, Done}, 64'd0);
            else begin
                e = scb.pop_front();
                chk("sb_hi", {32'd0, HiOut}, {32'd0, e.hi});
                chk("sb_lo", {32'd0, LoOut}, {32'd0, e.lo});
                chk("sb_dbz", {63'd0, DivByZero}, {63'd0, e.dbz});
                chk("sb_latency", 64'(cyc), 64'(e.cyc + 33));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        chk("rst_dbz", {63'd0, DivByZero}, 64'd0);
        chk("rst_hi", {32'd0, HiOut}, 64'd0);
        chk("rst_lo", {32'd0, LoOut}, 64'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // MULT -3 * 7 with per-cycle Busy
        issue(2'd0, 32'hFFFF_FFFD, 32'd7);
        for (int i = 1; i <= 33; i++) begin
            @(negedge Clk);
            chk("busy_calc", {63'd0, Busy}, 64'd1);
        end
        @(negedge Clk);
        chk("busy_done", {63'd0, Busy}, 64'd0);
        chk("done_34", {63'd0, Done}, 64'd1);
        chk("mult_hi", {32'd0, HiOut}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, LoOut}, 64'hFFFF_FFEB);
        @(negedge Clk);

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        chk("multu_hi", {32'd0, HiOut}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'd0, LoOut}, 64'h0000_0001);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        chk("div_lo", {32'd0, LoOut}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, HiOut}, 64'hFFFF_FFFF);
        @(negedge Clk);

        issue(2'd3, 32'd100, 32'd0);
        wait_done();
        chk("dz_flag", {63'd0, DivByZero}, 64'd1);
        chk("dz_hi", {32'd0, HiOut}, 64'h64);
        chk("dz_lo", {32'd0, LoOut}, 64'hFFFF_FFFF);
        @(negedge Clk);
        chk("dz_flag_after", {63'd0, DivByZero}, 64'd0);

        // Start during CALC is dropped; Start in the Done cycle chains
        issue(2'd3, 32'd50, 32'd7);
        repeat (4) @(negedge Clk);
        Start = 1'b1; Op = 2'd0; A = 32'd2; B = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        chk("ignored_busy", {63'd0, Busy}, 64'd1);
        wait_done();
        chk("divu_lo", {32'd0, LoOut}, 64'd7);
        chk("divu_hi", {32'd0, HiOut}, 64'd1);
        issue(2'd0, 32'd2, 32'd3);
        wait_done();
        chk("b2b_lo", {32'd0, LoOut}, 64'd6);
        @(negedge Clk);

        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        chk("ovf_lo", {32'd0, LoOut}, 64'h8000_0000);
        chk("ovf_hi", {32'd0, HiOut}, 64'd0);
        chk("ovf_dbz", {63'd0, DivByZero}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) @(negedge Clk);
            issue(2'($urandom_range(0, 3)), $urandom, (i % 4 == 0) ? 32'd0 : $urandom);
            wait_done();
        end

        // Async reset mid-MULT, with Start held during reset
        @(negedge Clk);
        issue(2'd0, 32'd5, 32'd5);
        repeat (9) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, Busy}, 64'd0);
        chk("arst_done", {63'd0, Done}, 64'd0);
        chk("arst_hi", {32'd0, HiOut}, 64'd0);
        chk("arst_lo", {32'd0, LoOut}, 64'd0);
        scb.delete();
        Start = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        Rst = 1'b0;
        repeat (40) @(negedge Clk);
        chk("post_rst_idle", {63'd0, Busy}, 64'd0);
        issue(2'd1, 32'd7, 32'd6);
        wait_done();
        chk("post_rst_lo", {32'd0, LoOut}, 64'd42);
        @(negedge Clk);
        chk("scb_empty", 64'(scb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
